// File: rtl/irq_ack_dispatcher_pkg.sv
// Shared constants, FSM state type and grant-decoding helpers for the
// interrupt acknowledge dispatcher.
package irq_pkg;

    localparam int unsigned NBUS_C = 3;
    localparam int unsigned NCH_C  = 9;
    localparam int unsigned NIRQ_C = NBUS_C * NCH_C;
    localparam int unsigned IDXW_C = 5;
    // Flat vectors are zero-padded to this width so any IDXW_C-bit index
    // selects a defined bit, even for an out-of-range grant.
    localparam int unsigned PADW_C = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        DROP
    } state_t;

    // Flat line index of (bus, chan); the highest set bus bit wins when
    // the bus select is not one-hot (such grants are rejected anyway).
    function automatic logic [IDXW_C-1:0] idx_of(input logic [NBUS_C-1:0] bus_onehot,
                                                 input logic [3:0]        chan);
        logic [IDXW_C-1:0] idx;
        idx = '0;
        for (int unsigned b = 0; b < NBUS_C; b++) begin
            if (bus_onehot[b]) begin
                idx = IDXW_C'(b * NCH_C + 32'(chan));
            end
        end
        return idx;
    endfunction

    function automatic logic onehot_ok(input logic [NBUS_C-1:0] bus);
        return ($countones(bus) == 1);
    endfunction

endpackage

// File: rtl/irq_ack_dispatcher_if.sv
// Grant handshake between the priority encoder (master) and the
// dispatcher (slave).
interface irq_ack_dispatcher_if #(
    parameter int unsigned NBUS = 3
) ();
    logic            gnt_valid;
    logic            gnt_ready;
    logic [NBUS-1:0] gnt_bus;
    logic [3:0]      gnt_chan;

    modport master (output gnt_valid, output gnt_bus, output gnt_chan, input gnt_ready);
    modport slave  (input gnt_valid, input gnt_bus, input gnt_chan, output gnt_ready);
endinterface

// File: rtl/irq_ack_dispatcher_pend.sv
// Rising-edge capture of the raw request lines into pending flags, with a
// single-bit clear port; a new edge on the cleared bit keeps it set.
module irq_pend_bank
    import irq_pkg::*;
#(
    parameter int unsigned NIRQ = NIRQ_C
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NIRQ-1:0]   irq_in,
    input  logic              clr_en,
    input  logic [IDXW_C-1:0] clr_idx,
    output logic [NIRQ-1:0]   pend
);
    logic [NIRQ-1:0]   irq_q;
    logic [NIRQ-1:0]   pend_q;
    logic [NIRQ-1:0]   pend_d;
    logic [PADW_C-1:0] clr_mask;

    // Next pending state: clear first, then OR in new rising edges.
    always_comb begin
        clr_mask = '0;
        if (clr_en) begin
            clr_mask = PADW_C'(1) << clr_idx;
        end
        pend_d = (pend_q & ~clr_mask[NIRQ-1:0]) | (irq_in & ~irq_q);
    end

    // Line history and pending flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q  <= '0;
            pend_q <= '0;
        end else begin
            irq_q  <= irq_in;
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;
endmodule

// File: rtl/irq_ack_dispatcher.sv
// Accepts encoder grants, drives a timed one-hot acknowledge to the granted
// source and waits for the source to drop its request line.
module irq_ack_dispatcher
    import irq_pkg::*;
#(
    parameter int unsigned NCH          = NCH_C,
    parameter int unsigned NBUS         = NBUS_C,
    parameter int unsigned ACK_CYCLES   = 2,
    parameter int unsigned DROP_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NBUS*NCH-1:0]  irq_in,
    output logic [NBUS*NCH-1:0]  pend_out,
    irq_ack_dispatcher_if.slave  gnt,
    output logic [NBUS*NCH-1:0]  ack_out,
    output logic                 busy,
    output logic                 err_bad_gnt,
    output logic                 err_timeout,
    output logic [7:0]           ack_cnt
);
    localparam int unsigned NIRQ = NBUS * NCH;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [IDXW_C-1:0] idx_q, idx_d;
    logic [7:0]        ack_cnt_q;
    logic              ready_q;
    logic              bad_q;
    logic              tmo_q;
    logic              tmo_d;
    logic              done_d;
    logic              clr_en;
    logic              xfer;
    logic              gnt_ok;
    logic [IDXW_C-1:0] gnt_idx;
    logic [PADW_C-1:0] pend_ext;
    logic [PADW_C-1:0] irq_ext;
    logic [PADW_C-1:0] ack_ext;

    irq_pend_bank #(
        .NIRQ(NIRQ)
    ) u_pend (
        .clk    (clk),
        .rst_n  (rst_n),
        .irq_in (irq_in),
        .clr_en (clr_en),
        .clr_idx(gnt_idx),
        .pend   (pend_out)
    );

    // Grant decode and validity check.
    always_comb begin
        pend_ext = PADW_C'(pend_out);
        irq_ext  = PADW_C'(irq_in);
        gnt_idx  = idx_of(gnt.gnt_bus, gnt.gnt_chan);
        xfer     = gnt.gnt_valid & ready_q;
        gnt_ok   = onehot_ok(gnt.gnt_bus) && (32'(gnt.gnt_chan) < NCH) && pend_ext[gnt_idx];
    end

    // Sequencer next state, timer and event strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        clr_en  = 1'b0;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer && gnt_ok) begin
                    idx_d   = gnt_idx;
                    clr_en  = 1'b1;
                    cnt_d   = 8'(ACK_CYCLES - 1);
                    state_d = ACK;
                end
            end
            ACK: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = 8'(DROP_TIMEOUT - 1);
                    state_d = DROP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DROP: begin
                if (!irq_ext[idx_q]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, timer, registered handshake/error outputs and completion count.
    // ready tracks the next state so it is low during reset and rises on the
    // first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            ready_q   <= 1'b0;
            bad_q     <= 1'b0;
            tmo_q     <= 1'b0;
            ack_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            ready_q   <= (state_d == IDLE);
            bad_q     <= xfer & ~gnt_ok;
            tmo_q     <= tmo_d;
            ack_cnt_q <= ack_cnt_q + {7'd0, done_d};
        end
    end

    // One-hot acknowledge decoded straight from state so reset drops it at once.
    always_comb begin
        ack_ext = '0;
        if (state_q == ACK) begin
            ack_ext = PADW_C'(1) << idx_q;
        end
        ack_out = ack_ext[NIRQ-1:0];
    end

    assign gnt.gnt_ready = ready_q;
    assign busy          = (state_q != IDLE);
    assign err_bad_gnt   = bad_q;
    assign err_timeout   = tmo_q;
    assign ack_cnt       = ack_cnt_q;
endmodule

// File: doc/irq_ack_dispatcher.md
Name: irq_ack_dispatcher

Overview:
- Requester-side companion to the team's 27-channel priority interrupt encoder (3 buses × 9 channels).
- Captures raw interrupt lines into pending flags and presents them per bus to the encoder.
- Accepts the encoder's grant (bus select + channel number) over a valid/ready handshake and drives a timed one-hot acknowledge back to the granted source.
- Sequences the source's request-drop, with error and timeout reporting.

Parameters:
- NCH, 9, channels per bus.
- NBUS, 3, number of buses (A, B, C).
- ACK_CYCLES, 2, cycles the ack line is held high (1..15).
- DROP_TIMEOUT, 15, max cycles to wait for the source to drop its line after ack (1..255).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq_in  in  NBUS*NCH  raw request lines, already synchronous to clk; bit index = bus*NCH+chan.
- pend_out  out  NBUS*NCH  registered pending flags, same indexing.
- gnt_valid  in  1  encoder presents a grant.
- gnt_ready  out  1  dispatcher can accept a grant.
- gnt_bus  in  NBUS  one-hot bus select (bit0=A).
- gnt_chan  in  4  channel number within bus.
- ack_out  out  NBUS*NCH  one-hot acknowledge.
- busy  out  1  acknowledge sequence in progress.
- err_bad_gnt  out  1  one-cycle pulse: rejected grant.
- err_timeout  out  1  one-cycle pulse: source failed to drop its line.
- ack_cnt  out  8  count of completed acks, wraps 255->0.

Behaviour:
- Reset (async assert, sync release):
  - pend_out, ack_out, ack_cnt, irq_q = 0.
  - busy, err_bad_gnt, err_timeout = 0.
  - gnt_ready = 0; FSM = IDLE.
  - gnt_ready rises on the first clk edge after release.
- Edge capture:
  - irq_q is irq_in delayed one cycle.
  - A rising edge (irq_in & ~irq_q) sets the pending bit on the next edge, so pend_out latency is 1 cycle.
  - A line held high does not re-set the bit after it is cleared.
- Pending clear: the pending bit is cleared on the edge that accepts a valid grant for it. If a rising edge and the clear coincide on the same bit, set wins.
- Handshake:
  - gnt_ready = 1 only in IDLE.
  - A transfer occurs on an edge with gnt_valid & gnt_ready.
  - The encoder holds the grant until the transfer.
  - gnt_* are ignored outside a transfer.
- Grant validity requires all three of:
  - gnt_bus has exactly one bit set;
  - gnt_chan < NCH;
  - pend_out at index bus*NCH+chan is 1.
- Invalid grant: err_bad_gnt pulses high for the cycle after the transfer; FSM stays IDLE; no pending change, no ack.
- FSM states:
  - IDLE: on valid transfer, latch idx, clear pending, cnt=ACK_CYCLES-1, go to ACK.
  - ACK:
    - ack_out[idx]=1, busy=1; cnt decrements each cycle.
    - At cnt==0, go to DROP with cnt=DROP_TIMEOUT-1.
    - Ack is high exactly ACK_CYCLES cycles, first cycle one after the transfer edge.
  - DROP:
    - busy=1, ack_out=0.
    - If irq_in[idx]==0, go to IDLE and ack_cnt+1.
    - Else if cnt==0, go to IDLE, pulse err_timeout 1 cycle, ack_cnt unchanged.
    - Else decrement cnt.
- A new rising edge on other lines during ACK/DROP still sets pending normally.
- Reset mid-operation aborts the sequence immediately; ack_out drops asynchronously.
- Timer is 8-bit; behaviour for parameters outside the stated ranges is unsupported.

Decomposition:
- Package irq_pkg:
  - constants NBUS_C=3, NCH_C=9, NIRQ_C=27;
  - enum state_t {IDLE, ACK, DROP};
  - function idx_of(bus_onehot, chan) returning the flat index;
  - function onehot_ok(bus).
- One sub-module, irq_pend_bank: edge detect plus the pending set/clear register array (inputs irq_in, clr_en, clr_idx; output pend). The FSM, timer and counters stay in the top.

Test Plan:
- Reset / pend: rst_n low then high; pulse irq_in[12] (B, chan 3) high → pend_out[12]=1 one cycle after the edge; all outputs 0 during reset.
- Normal ack, ACK_CYCLES=2:
  - pend[12]=1; grant bus=3'b010, chan=3 → gnt_ready low next cycle, ack_out[12] high exactly 2 cycles, pend_out[12]=0.
  - Source drops irq_in[12] 3 cycles later → busy low, ack_cnt=1.
- Bad grants:
  - bus=3'b011 → err_bad_gnt pulse, no ack.
  - chan=9 → err_bad_gnt pulse, no ack.
  - bus=3'b001 chan=0 with pend[0]=0 → err_bad_gnt pulse, no ack.
- Timeout: grant pend[26] (bus=3'b100, chan=8); hold irq_in[26] high → err_timeout pulse 15 cycles after the ack ends, ack_cnt unchanged, gnt_ready=1.
- Simultaneous events: rising edge on irq_in[5] during ACK for idx 5's neighbour 4 → pend_out[5]=1. Rising edge on bit 4 in the same cycle as its grant → pend_out[4] stays 1.
- Reset mid-ACK: drop rst_n while ack_out[7]=1 → ack_out=0 immediately; after release FSM is IDLE and pending is all 0.
